lsu_mem_access: RTL

- Memory-stage load/store unit. Consumes the EX-stage ALU result as the effective address and the EX-stage rs2 value as store data.
- Drives the data-memory request/acknowledge interface, then returns aligned, sign- or zero-extended load data to writeback.
- Holds the pipeline through stallreq_o while a memory transaction is outstanding.
- Flags misaligned accesses and memory timeouts as errors.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/lsu_mem_access.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Store byte-lane replication / enables and load extract with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be_c,
  output logic [31:0] o_wdata_c,
  output logic [31:0] o_rdata_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Selected lane shifted down to bit 0; half accesses are always half-aligned here.
  assign w_byte = 8'(i_rdata >> {i_addr_lo, 3'b000});
  assign w_half = 16'(i_rdata >> {i_addr_lo[1], 4'b0000});

  always_comb begin
    o_be_c    = 4'b0000;
    o_wdata_c = 32'h0;
    o_rdata_c = 32'h0;
    case (i_size)
      SZ_B: begin
        o_be_c    = 4'b0001 << i_addr_lo;
        o_wdata_c = {4{i_wdata[7:0]}};
        o_rdata_c = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_be_c    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_c = {2{i_wdata[15:0]}};
        o_rdata_c = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      SZ_W: begin
        o_be_c    = 4'b1111;
        o_wdata_c = i_wdata;
        o_rdata_c = i_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Memory-stage load/store unit: request/ack data-memory handshake, pipeline stall,
// misalignment and timeout error reporting.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DM_AW   = 14,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [3:0]        dm_be_o,
  output logic [DM_AW-1:0]  dm_addr_o,
  output logic [31:0]       dm_wdata_o,
  input  logic [31:0]       dm_rdata_i,
  input  logic              dm_ack_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              stallreq_o
);

  localparam int unsigned TMR_W = 8;

  lsu_state_e         r_state, w_state_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic [DM_AW-1:0]   r_waddr;
  logic [1:0]         r_addr_lo;
  logic [1:0]         r_size;
  logic               r_we;
  logic               r_uns;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               w_latch;
  logic               w_cap;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_lane;
  logic [31:0]        w_rdata_ext;
  logic               w_unused_addr;

  assign w_unused_addr = ^addr_i[ADDR_W-1:DM_AW+2];

  lsu_lane_align u_lane (
    .i_size     (r_size),
    .i_addr_lo  (r_addr_lo),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .i_rdata    (dm_rdata_i),
    .o_be_c     (w_be),
    .o_wdata_c  (w_wdata_lane),
    .o_rdata_c  (w_rdata_ext)
  );

  // Next-state, timer and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_latch     = 1'b0;
    w_cap       = 1'b0;
    dm_req_o    = 1'b0;
    dm_we_o     = 1'b0;
    dm_be_o     = 4'b0000;
    dm_addr_o   = '0;
    dm_wdata_o  = 32'h0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i) begin
          w_timer_nxt = '0;
          if (is_misaligned(mem_size_i, addr_i[1:0])) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt = ST_REQ;
            w_latch     = 1'b1;
          end
        end
      end
      ST_REQ: begin
        dm_req_o   = 1'b1;
        dm_we_o    = r_we;
        dm_be_o    = w_be;
        dm_addr_o  = r_waddr;
        dm_wdata_o = w_wdata_lane;
        // Ack takes priority over a coinciding timeout
        if (dm_ack_i) begin
          w_state_nxt = ST_DONE;
          w_cap       = ~r_we;
          w_timer_nxt = '0;
        end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
          w_state_nxt = ST_ERR;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ST_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        err_o       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Gated by rst_n so the pipeline is released the instant reset is applied
  assign stallreq_o = rst_n & (((r_state == ST_IDLE) & mem_req_i) | (r_state == ST_REQ));
  assign rdata_o    = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_waddr   <= '0;
      r_addr_lo <= 2'b00;
      r_size    <= 2'b00;
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_wdata   <= 32'h0;
      r_rdata   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      if (w_latch) begin
        r_waddr   <= addr_i[DM_AW+1:2];
        r_addr_lo <= addr_i[1:0];
        r_size    <= mem_size_i;
        r_we      <= mem_we_i;
        r_uns     <= mem_unsigned_i;
        r_wdata   <= wdata_i;
      end
      if (w_cap) r_rdata <= w_rdata_ext;
    end
  end

endmodule
